threed_render_hls_udiv_30ns_15ns_seq: RTL and testbench

//  Sequential unsigned divider; the inverse of the 15x15->30 pipelined multiplier used by the render datapath.

---
 rtl/threed_render_hls_div_pkg.sv | 20 ++
 rtl/threed_render_hls_udiv_step.sv | 23 ++
 rtl/threed_render_hls_udiv_30ns_15ns_seq.sv | 142 ++++++++++++++
 tb/tb_threed_render_hls_udiv_30ns_15ns_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/threed_render_hls_div_pkg.sv
// Shared types and sizing for the render-datapath sequential unsigned divider.
// The state encoding is also visible on the divider's state_dbg output.
package threed_render_hls_div_pkg;

    localparam int DIVIDEND_W_DEF = 30;
    localparam int DIVISOR_W_DEF  = 15;
    localparam int CNT_W_DEF      = $clog2(DIVIDEND_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Counter width for n iterations, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/threed_render_hls_udiv_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module threed_render_hls_udiv_step #(
    parameter int DIVISOR_W = 15
) (
    input  logic [DIVISOR_W:0]   prem_in,
    input  logic                 msb_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   prem_out,
    output logic                 qbit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] diff;

    assign shifted = {prem_in, msb_in};
    assign diff    = shifted - {2'b00, divisor};

    // shifted < 2*divisor, so the top bit of diff is a clean borrow flag.
    assign qbit     = ~diff[DIVISOR_W+1];
    assign prem_out = qbit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];

endmodule

// File: rtl/threed_render_hls_udiv_30ns_15ns_seq.sv
// Sequential radix-2 restoring unsigned divider with valid/ready on both sides
// and an HLS-style clock enable that freezes every register when low.
module threed_render_hls_udiv_30ns_15ns_seq
    import threed_render_hls_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic [1:0]            state_dbg
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);

    // Handshake: a transfer occurs on a rising edge where ce, valid and ready
    // are all 1. in_ready is high only in IDLE, out_valid only in DONE, so
    // accepting an operand and handing off a result never share a cycle.

    div_state_e            state;
    div_state_e            state_next;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] dvd_sr;
    logic [DIVISOR_W:0]    prem;
    logic [DIVISOR_W-1:0]  dvs;
    logic                  dbz_pend;
    logic [DIVIDEND_W-1:0] quotient_r;
    logic [DIVISOR_W-1:0]  remainder_r;
    logic                  dbz_r;

    logic                  load_op;
    logic                  step_en;
    logic                  finish;
    logic [DIVISOR_W:0]    prem_next;
    logic                  qbit;
    logic [DIVIDEND_W-1:0] quot_next;

    threed_render_hls_udiv_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .prem_in  (prem),
        .msb_in   (dvd_sr[DIVIDEND_W-1]),
        .divisor  (dvs),
        .prem_out (prem_next),
        .qbit     (qbit)
    );

    // The dividend register doubles as the quotient: each step shifts one
    // dividend bit out of the top and one quotient bit into the bottom.
    assign quot_next = {dvd_sr[DIVIDEND_W-2:0], qbit};

    always_comb begin
        state_next = state;
        load_op    = 1'b0;
        step_en    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load_op    = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                step_en = 1'b1;
                if (cnt == '0) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd_sr      <= '0;
            prem        <= '0;
            dvs         <= '0;
            dbz_pend    <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else if (ce) begin
            state <= state_next;
            if (load_op) begin
                dvs      <= divisor;
                dvd_sr   <= dividend;
                prem     <= '0;
                dbz_pend <= (divisor == '0);
                // A zero divisor spends a single CALC cycle, giving the
                // one-edge result latency without a separate state.
                cnt      <= (divisor == '0) ? '0 : CNT_W'(DIVIDEND_W - 1);
            end
            if (step_en) begin
                dvd_sr <= quot_next;
                prem   <= prem_next;
                if (!finish) begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
            if (finish) begin
                if (dbz_pend) begin
                    quotient_r  <= '1;
                    remainder_r <= dvd_sr[DIVISOR_W-1:0];
                    dbz_r       <= 1'b1;
                end else begin
                    quotient_r  <= quot_next;
                    remainder_r <= prem_next[DIVISOR_W-1:0];
                    dbz_r       <= 1'b0;
                end
            end
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;
    assign state_dbg   = state;

endmodule

// File: tb/tb_threed_render_hls_udiv_30ns_15ns_seq.sv
// Scoreboard bench for the sequential divider: directed latency, backpressure,
// stall and reset cases followed by randomized operands.
module tb_threed_render_hls_udiv_30ns_15ns_seq;

    localparam int DW = 30;
    localparam int SW = 15;
    localparam int RW = 1 + SW + DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ce = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [SW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;
    logic [1:0]    state_dbg;

    threed_render_hls_udiv_30ns_15ns_seq dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [RW-1:0] exp_q[$];
    int            lat_q[$];
    int            total = 0;
    int            bad = 0;
    int            last_accept = 0;
    logic          prev_valid = 1'b0;

    logic          rand_ce = 1'b0;
    logic          rand_ready = 1'b0;
    logic          ce_force = 1'b1;
    logic          ready_force = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout or missing entry (cycle %0d)", name, cyc);
    endtask

    // Reference model straight from the arithmetic definition.
    function automatic logic [RW-1:0] ref_div(input logic [DW-1:0] a, input logic [SW-1:0] b);
        longint unsigned q;
        longint unsigned r;
        if (b == '0) return {1'b1, a[SW-1:0], {DW{1'b1}}};
        q = longint'(a) / longint'(b);
        r = longint'(a) % longint'(b);
        return {1'b0, SW'(r), DW'(q)};
    endfunction

    // ---------------- background ce / out_ready driver ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ce) ce = ($urandom_range(0, 9) != 0);
            else ce = ce_force;
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
            else out_ready = ready_force;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DW-1:0] a, input logic [SW-1:0] b,
                        input bit chk_lat, input int adj);
        int n;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        n = 0;
        forever begin
            #3;
            if (in_ready && ce) break;
            n++;
            if (n > 2000) break;
            @(negedge clk);
        end
        if (n > 2000) begin
            fail_now("accept");
        end else begin
            last_accept = cyc + 1;
            exp_q.push_back(ref_div(a, b));
            lat_q.push_back(chk_lat ? last_accept + ((b == '0) ? 1 : DW) + adj : -1);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain");
    endtask

    task automatic sample();
        @(negedge clk);
        #3;
    endtask

    // ---------------- monitor ----------------
    initial begin
        int l;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                if (out_valid && !prev_valid) begin
                    if (lat_q.size() == 0) fail_now("latency_q");
                    else begin
                        l = lat_q.pop_front();
                        if (l >= 0) check("latency", 64'(cyc), 64'(l));
                    end
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) fail_now("result_q");
                    else begin
                        check("result", 64'({div_by_zero, remainder, quotient}), 64'(exp_q[0]));
                        check("in_ready_in_done", 64'(in_ready), 64'd0);
                        if (out_ready && ce) void'(exp_q.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int t1;
        int n;
        logic [DW-1:0] a;
        logic [SW-1:0] b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        reset = 1'b1;

        ready_force = 1'b1;
        send(30'd1000000, 15'd1000, 1'b1, 0);
        drain();

        // back-to-back operations with out_ready held high
        send(30'h3FFFFFFF, 15'h7FFF, 1'b1, 0);
        t1 = last_accept;
        send(30'd7, 15'd3, 1'b1, 0);
        check("throughput", 64'(last_accept - t1), 64'(DW + 2));
        drain();

        send(30'd12345, 15'd0, 1'b1, 0);
        send(30'd54321, 15'd1, 1'b1, 0);
        drain();

        // backpressure: hold out_ready low for five DONE cycles
        ready_force = 1'b0;
        send(30'd999, 15'd10, 1'b1, 0);
        n = 0;
        forever begin
            sample();
            if (out_valid || n > 200) break;
            n++;
        end
        if (!out_valid) fail_now("bp_wait");
        repeat (5) @(posedge clk);
        ready_force = 1'b1;
        sample();
        check("bp_held_valid", 64'(out_valid), 64'd1);
        check("bp_held_in_ready", 64'(in_ready), 64'd0);
        sample();
        check("bp_after_in_ready", 64'(in_ready), 64'd1);
        check("bp_after_out_valid", 64'(out_valid), 64'd0);
        drain();

        // three ce-low cycles in the middle of CALC
        send(30'd1000000, 15'd1000, 1'b1, 3);
        repeat (5) @(posedge clk);
        ce_force = 1'b0;
        repeat (3) @(posedge clk);
        ce_force = 1'b1;
        drain();

        // reset around iteration 10 abandons the operation
        send(30'd1000000, 15'd1000, 1'b1, 0);
        repeat (8) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        lat_q.delete();
        sample();
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_quotient", 64'(quotient), 64'd0);
        check("mid_rst_remainder", 64'(remainder), 64'd0);
        check("mid_rst_dbz", 64'(div_by_zero), 64'd0);
        send(30'd7, 15'd3, 1'b1, 0);
        drain();

        // randomized operands, random backpressure, latency still checked
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = DW'($urandom() >> 2);
            if ($urandom_range(0, 7) == 0) a = DW'($urandom_range(0, 40));
            case ($urandom_range(0, 9))
                0: b = '0;
                1: b = SW'(1);
                2, 3: b = SW'($urandom_range(2, 15));
                default: b = SW'($urandom_range(1, 32767));
            endcase
            send(a, b, 1'b1, 0);
        end
        drain();

        // randomized ce stalls on top of that
        rand_ce = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = DW'($urandom() >> 2);
            b = ($urandom_range(0, 9) == 0) ? SW'(0) : SW'($urandom_range(1, 32767));
            send(a, b, 1'b0, 0);
        end
        drain();
        rand_ce = 1'b0;
        rand_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
